hilotof_word_tx: RTL and testbench

HILOTOF_WORD_TX -- requirements
Module: hilotof_word_tx

---
 rtl/hilotof_word_tx.sv | 119 +++++++++++
 tb/tb_hilotof_word_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hilotof_word_tx.sv
// hilotof_word_tx: buffers 32-bit result words in a FIFO and sends each one LSB byte first as 8N1 UART frames
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   dout_valid, dout  incoming result word, accepted when dout_ready is also high
//   dout_ready        FIFO has room (held low until the first edge after reset)
//   uart_tx           registered serial line, idle high
//   busy              FIFO non-empty or a frame in flight
module hilotof_word_tx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dout_valid,
  input  logic [31:0] dout,
  output logic        dout_ready,
  output logic        uart_tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic ready_en, push, pop, empty, expire;
  logic [1:0] byte_idx, byte_idx_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [15:0] baud, baud_n;
  logic [31:0] shreg, shreg_n;

  assign empty      = count == '0;
  assign dout_ready = ready_en && count < CW'(FIFO_DEPTH);
  assign push       = dout_valid && dout_ready;
  assign busy       = state != IDLE || !empty;
  assign expire     = baud == '0;

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= dout;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count    <= count + CW'(push) - CW'(pop);
    end

  // The shift register feeds bit 0 to the line; shifting once per data bit
  // walks the four bytes out LSB first without a separate byte mux.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    pop        = 1'b0;
    baud_n     = expire ? RELOAD : baud - 16'd1;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          state_n    = START;
          pop        = 1'b1;
          shreg_n    = mem[rd_ptr];
          byte_idx_n = '0;
          baud_n     = RELOAD;
        end
      end
      START: if (expire) state_n = DATA;
      DATA: if (expire) begin
        shreg_n   = shreg >> 1;
        bit_idx_n = bit_idx + 3'd1;
        state_n   = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (expire) begin
        if (byte_idx != 2'd3) begin
          byte_idx_n = byte_idx + 2'd1;
          state_n    = START;
        end else if (!empty) begin
          state_n    = START;
          pop        = 1'b1;
          shreg_n    = mem[rd_ptr];
          byte_idx_n = '0;
        end else begin
          state_n    = IDLE;
          byte_idx_n = '0;
          baud_n     = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // uart_tx is registered from the current state, so the line trails the FSM
  // by one cycle; every bit still lasts exactly CLK_DIV cycles.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud     <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      bit_idx  <= bit_idx_n;
      baud     <= baud_n;
      shreg    <= shreg_n;
      uart_tx  <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    end
endmodule

// File: tb/tb_hilotof_word_tx.sv
// tb_hilotof_word_tx: randomized self-checking bench against a timing-level line model
module tb_hilotof_word_tx;
  localparam int CD = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CD;
  localparam int WORD = 4 * FRAME;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dout_valid = 1'b0;
  logic [31:0] dout = '0;
  logic dout_ready, uart_tx, busy;
  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int rel_edge = 0;
  int dut_acc = 0;
  int last_p = -100000;
  int aq[$];
  int pq[$];
  logic [31:0] wq[$];

  hilotof_word_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .dout_valid(dout_valid), .dout(dout),
    .dout_ready(dout_ready), .uart_tx(uart_tx), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  // Model: word i accepted at edge aq[i], popped at edge pq[i], line low from pq[i]+1
  // for WORD cycles. Values describe outputs just after edge t.
  function automatic int occ(input int t);
    int n = 0;
    foreach (aq[i]) if (aq[i] <= t && t < pq[i]) n++;
    return n;
  endfunction

  function automatic logic f_ready(input int t);
    return !reset && t > rel_edge && occ(t) < DEPTH;
  endfunction

  function automatic logic f_busy(input int t);
    foreach (aq[i]) if (aq[i] <= t && t < pq[i] + WORD) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic f_tx(input int t);
    int o, by, bt;
    foreach (pq[i]) begin
      o = t - pq[i] - 1;
      if (o >= 0 && o < WORD) begin
        by = o / FRAME;
        bt = (o % FRAME) / CD;
        if (bt == 0) return 1'b0;
        if (bt == 9) return 1'b1;
        return wq[i][by * 8 + bt - 1];
      end
    end
    return 1'b1;
  endfunction

  always @(negedge clock) begin : mon
    int a, p;
    if (reset) begin
      aq.delete();
      pq.delete();
      wq.delete();
      last_p = -100000;
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ready", dout_ready, 0);
    end else begin
      check("ready", dout_ready, f_ready(edge_n));
      check("busy", busy, f_busy(edge_n));
      check("tx", uart_tx, f_tx(edge_n));
      if (dout_valid && dout_ready) dut_acc++;
      if (dout_valid && f_ready(edge_n)) begin
        a = edge_n + 1;
        p = (a + 1 > last_p + WORD) ? a + 1 : last_p + WORD;
        aq.push_back(a);
        pq.push_back(p);
        wq.push_back(dout);
        last_p = p;
      end
      while (pq.size() > 0 && edge_n > pq[0] + WORD + 2) begin
        void'(aq.pop_front());
        void'(pq.pop_front());
        void'(wq.pop_front());
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    dout = w;
    dout_valid = 1'b1;
    @(negedge clock);
    while (!f_ready(edge_n) && n < 2000) begin
      n++;
      @(negedge clock);
    end
    check("push_wait_ok", n < 2000, 1);
    @(posedge clock);
    #1 dout_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while ((busy || f_busy(edge_n)) && n < 5000) begin
      n++;
      @(negedge clock);
    end
    check("idle_wait_ok", n < 5000, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int a1, base, lows;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    rel_edge = edge_n;
    @(negedge clock);
    check("ready_rel0", dout_ready, 0);
    @(negedge clock);
    check("ready_rel1", dout_ready, 1);
    repeat (3) @(posedge clock);
    #1;
    push_word(32'h44332211);
    a1 = edge_n;
    while (uart_tx && edge_n - a1 < 20) @(negedge clock);
    check("latency", edge_n - a1, 2);
    while (busy && edge_n - a1 < 1000) @(negedge clock);
    check("busy_fall", edge_n - a1, 1 + WORD);
    wait_idle();
    base = dut_acc;
    for (int i = 0; i < 5; i++) push_word($urandom);
    dout = 32'hC0FFEE06;
    dout_valid = 1'b1;
    repeat (20) @(negedge clock);
    check("accepted5", dut_acc - base, 5);
    check("ready_low_full", dout_ready, 0);
    push_word(32'hC0FFEE06);
    wait_idle();
    push_word(32'h000000FF);
    push_word(32'hFFFFFF00);
    wait_idle();
    base = dut_acc;
    for (int i = 0; i < 5; i++) push_word($urandom);
    for (int i = 0; i < 40; i++) begin
      dout = $urandom;
      dout_valid = i[0];
      @(posedge clock);
      #1;
    end
    dout_valid = 1'b0;
    check("full_no_accept", dut_acc - base, 5);
    wait_idle();
    push_word(32'h5A00C3E1);
    for (int i = 0; i < 3; i++) push_word($urandom);
    repeat (90) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_busy", busy, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    rel_edge = edge_n;
    lows = 0;
    repeat (300) begin
      @(negedge clock);
      lows += int'(!uart_tx);
    end
    check("no_resume", lows, 0);
    check("no_resume_busy", busy, 0);
    @(posedge clock);
    #1;
    push_word(32'hA5A5A5A5);
    wait_idle();
    repeat (12) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(100, 250) : $urandom_range(0, 20)) @(posedge clock);
      #1;
      push_word($urandom);
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
